aes_simple_dec: RTL



---
 rtl/aes_simple_dec.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/aes_simple_dec.sv
// Iterative AES-128 ECB decryption core, one inverse round per clock.
// Round keys are regenerated backwards from K10, which is cached per key.
module aes_simple_dec (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic [127:0] plaintext
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] KEYEXP = 2'd1;
    localparam logic [1:0] DEC    = 2'd2;

    logic [1:0]   state;
    logic [127:0] ct_r;
    logic [127:0] rk;
    logic [127:0] st;
    logic [127:0] key_c;
    logic [127:0] k10_c;
    logic [3:0]   kr;
    logic [3:0]   rnd;
    logic         cache_v;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = ginv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
                 ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return ginv({y[6:0], y[7]} ^ {y[4:0], y[7:5]}
                    ^ {y[1:0], y[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] =
                    inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] =
                    gmul(8'h0e, a[r]) ^ gmul(8'h0b, a[(r+1)%4])
                  ^ gmul(8'h0d, a[(r+2)%4]) ^ gmul(8'h09, a[(r+3)%4]);
            end
        end
        return o;
    endfunction

    logic [31:0]  w3_inv;
    logic [31:0]  sw_in;
    logic [31:0]  sw_out;
    logic [31:0]  f0, f1, f2, f3;
    logic [31:0]  i0, i1, i2;
    logic [127:0] rk_fwd;
    logic [127:0] rk_inv;
    logic [127:0] dec_t;

    // The four key-schedule S-boxes are shared by both directions.
    assign w3_inv = rk[31:0] ^ rk[63:32];
    assign sw_in  = (state == DEC) ? w3_inv : rk[31:0];
    assign sw_out = {sbox(sw_in[23:16]), sbox(sw_in[15:8]),
                     sbox(sw_in[7:0]), sbox(sw_in[31:24])};

    assign f0 = rk[127:96] ^ sw_out ^ {rcon(kr), 24'h0};
    assign f1 = rk[95:64] ^ f0;
    assign f2 = rk[63:32] ^ f1;
    assign f3 = rk[31:0] ^ f2;
    assign rk_fwd = {f0, f1, f2, f3};

    assign i2 = rk[63:32] ^ rk[95:64];
    assign i1 = rk[95:64] ^ rk[127:96];
    assign i0 = rk[127:96] ^ sw_out ^ {rcon(rnd), 24'h0};
    assign rk_inv = {i0, i1, i2, w3_inv};

    assign dec_t = inv_sr_sb(st) ^ rk_inv;
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ct_r      <= '0;
            rk        <= '0;
            st        <= '0;
            key_c     <= '0;
            k10_c     <= '0;
            kr        <= '0;
            rnd       <= '0;
            cache_v   <= 1'b0;
            done      <= 1'b0;
            plaintext <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (cache_v && key == key_c) begin
                            st    <= ciphertext ^ k10_c;
                            rk    <= k10_c;
                            rnd   <= 4'd9;
                            state <= DEC;
                        end else begin
                            ct_r    <= ciphertext;
                            key_c   <= key;
                            rk      <= key;
                            kr      <= 4'd0;
                            cache_v <= 1'b0;
                            state   <= KEYEXP;
                        end
                    end
                end
                KEYEXP: begin
                    rk <= rk_fwd;
                    if (kr == 4'd9) begin
                        k10_c   <= rk_fwd;
                        cache_v <= 1'b1;
                        st      <= ct_r ^ rk_fwd;
                        rnd     <= 4'd9;
                        state   <= DEC;
                    end else begin
                        kr <= kr + 4'd1;
                    end
                end
                DEC: begin
                    rk <= rk_inv;
                    if (rnd != 4'd0) begin
                        st  <= inv_mix(dec_t);
                        rnd <= rnd - 4'd1;
                    end else begin
                        plaintext <= dec_t;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
